// File: rtl/spike_pair_gen.sv
// Spike pair generator: bursts of NPAIRS A/B spike pairs on UP or DOWN lines.
// Ports: clk, rst_n, start, dir, abort -> a_up, a_down, b_up, b_down, busy, done.
module spike_pair_gen #(
   parameter int GAP_CYC   = 123,
   parameter int SPIKE_CYC = 10,
   parameter int SEP_CYC   = 10,
   parameter int NPAIRS    = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic dir,
   input  logic abort,
   output logic a_up,
   output logic a_down,
   output logic b_up,
   output logic b_down,
   output logic busy,
   output logic done
);

   localparam int MAXV = (GAP_CYC > SPIKE_CYC)
                       ? ((GAP_CYC > SEP_CYC) ? GAP_CYC : SEP_CYC)
                       : ((SPIKE_CYC > SEP_CYC) ? SPIKE_CYC : SEP_CYC);
   localparam int CW = ($clog2(MAXV + 1) > 16) ? $clog2(MAXV + 1) : 16;
   localparam int PW = ($clog2(NPAIRS + 1) > 8) ? $clog2(NPAIRS + 1) : 8;

   typedef enum logic [2:0] {
      IDLE, GAP, SPK_A, SEP, SPK_B, TAIL, FIN
   } state_t;

   state_t        state, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [PW-1:0] pair, pair_nxt;
   logic          dir_q, dir_nxt;
   logic          last;

   logic a_up_nxt, a_down_nxt, b_up_nxt, b_down_nxt;
   logic busy_nxt, done_nxt;

   assign last = (cnt == '0);

   // State and counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         pair   <= '0;
         dir_q  <= 1'b0;
         a_up   <= 1'b0;
         a_down <= 1'b0;
         b_up   <= 1'b0;
         b_down <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_nxt;
         pair   <= pair_nxt;
         dir_q  <= dir_nxt;
         a_up   <= a_up_nxt;
         a_down <= a_down_nxt;
         b_up   <= b_up_nxt;
         b_down <= b_down_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

   // Next-state and counter logic
   always_comb begin
      nxt      = state;
      cnt_nxt  = last ? '0 : cnt - 1'b1;
      pair_nxt = pair;
      dir_nxt  = dir_q;
      if (abort) begin
         nxt      = IDLE;
         cnt_nxt  = '0;
         pair_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  nxt      = GAP;
                  cnt_nxt  = CW'(GAP_CYC - 1);
                  pair_nxt = '0;
                  dir_nxt  = dir;
               end
            end
            GAP: begin
               if (last) begin
                  nxt     = SPK_A;
                  cnt_nxt = CW'(SPIKE_CYC - 1);
               end
            end
            SPK_A: begin
               if (last) begin
                  nxt     = SEP;
                  cnt_nxt = CW'(SEP_CYC - 1);
               end
            end
            SEP: begin
               if (last) begin
                  nxt     = SPK_B;
                  cnt_nxt = CW'(SPIKE_CYC - 1);
               end
            end
            SPK_B: begin
               if (last) begin
                  cnt_nxt = CW'(GAP_CYC - 1);
                  if (pair == PW'(NPAIRS - 1)) begin
                     nxt = TAIL;
                  end else begin
                     nxt      = GAP;
                     pair_nxt = pair + 1'b1;
                  end
               end
            end
            TAIL: begin
               if (last) begin
                  nxt     = FIN;
                  cnt_nxt = '0;
               end
            end
            FIN: begin
               nxt = IDLE;
               if (start) begin
                  pair_nxt = '0;
                  dir_nxt  = dir;
                  // The FIN cycle itself is the first idle cycle of a
                  // back-to-back burst, so the gap is one cycle shorter.
                  if (GAP_CYC > 1) begin
                     nxt     = GAP;
                     cnt_nxt = CW'(GAP_CYC - 2);
                  end else begin
                     nxt     = SPK_A;
                     cnt_nxt = CW'(SPIKE_CYC - 1);
                  end
               end
            end
            default: begin
               nxt      = IDLE;
               cnt_nxt  = '0;
               pair_nxt = '0;
            end
         endcase
      end
   end

   // Output decode from the next state, so outputs are registered
   always_comb begin
      a_up_nxt   = (nxt == SPK_A) && !dir_nxt;
      a_down_nxt = (nxt == SPK_A) &&  dir_nxt;
      b_up_nxt   = (nxt == SPK_B) && !dir_nxt;
      b_down_nxt = (nxt == SPK_B) &&  dir_nxt;
      busy_nxt   = (nxt != IDLE) && (nxt != FIN);
      done_nxt   = (nxt == FIN);
   end

endmodule
